// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the fetch controller       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;

   localparam logic [31:0] C_RESET_PC = 32'h0000_3000;

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_ctrl_if : imem, decode and next-PC signals of the fetch stage   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface fetch_ctrl_if;

   logic [31:0] npc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic [31:0] retire_cnt;

   modport master (
      input  npc, redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
      output imem_req, imem_addr, inst_valid, inst, inst_pc, retire_cnt
   );

   modport slave (
      output npc, redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
      input  imem_req, imem_addr, inst_valid, inst, inst_pc, retire_cnt
   );

endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_ctrl : PC owner, single-outstanding imem fetch, decode handoff  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = C_RESET_PC
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   fetch_ctrl_if.master   bus
);

   fetch_state_t r_state,      w_state_nxt;
   logic [31:0]  r_pc,         w_pc_nxt;
   logic [31:0]  r_imem_addr,  w_addr_nxt;
   logic [31:0]  r_inst,       w_inst_nxt;
   logic [31:0]  r_inst_pc,    w_inst_pc_nxt;
   logic [31:0]  r_retire_cnt, w_cnt_nxt;
   logic [31:0]  w_redir_pc;
   logic [31:0]  w_npc;
   logic [31:0]  w_drain_pc;

   assign w_redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;
   assign w_npc      = bus.npc         & 32'hFFFF_FFFC;
   assign w_drain_pc = bus.redirect_valid ? w_redir_pc : r_pc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_pc         <= RESET_PC;
         r_imem_addr  <= RESET_PC;
         r_inst       <= 32'd0;
         r_inst_pc    <= 32'd0;
         r_retire_cnt <= 32'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_imem_addr  <= w_addr_nxt;
         r_inst       <= w_inst_nxt;
         r_inst_pc    <= w_inst_pc_nxt;
         r_retire_cnt <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_addr_nxt     = r_imem_addr;
      w_inst_nxt     = r_inst;
      w_inst_pc_nxt  = r_inst_pc;
      w_cnt_nxt      = r_retire_cnt;
      bus.imem_req   = 1'b0;
      bus.inst_valid = 1'b0;

      case (r_state)
         IDLE: begin
            w_state_nxt = FETCH;
            w_addr_nxt  = r_pc;
         end
         FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.redirect_valid) begin
               w_pc_nxt = w_redir_pc;
               // Ack coinciding with a redirect: drop the word, relaunch at the target.
               if (bus.imem_ack) begin
                  w_addr_nxt = w_redir_pc;
               end else begin
                  w_state_nxt = DRAIN;
               end
            end else if (bus.imem_ack) begin
               w_inst_nxt    = bus.imem_rdata;
               w_inst_pc_nxt = r_imem_addr;
               w_state_nxt   = HOLD;
            end
         end
         DRAIN: begin
            bus.imem_req = 1'b1;
            w_pc_nxt     = w_drain_pc;
            if (bus.imem_ack) begin
               w_addr_nxt  = w_drain_pc;
               w_state_nxt = FETCH;
            end
         end
         HOLD: begin
            bus.inst_valid = !bus.redirect_valid;
            if (bus.redirect_valid) begin
               w_pc_nxt    = w_redir_pc;
               w_addr_nxt  = w_redir_pc;
               w_state_nxt = FETCH;
            end else if (bus.inst_ready) begin
               w_pc_nxt    = w_npc;
               w_addr_nxt  = w_npc;
               w_cnt_nxt   = r_retire_cnt + 32'd1;
               w_state_nxt = FETCH;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign bus.imem_addr  = r_imem_addr;
   assign bus.inst       = r_inst;
   assign bus.inst_pc    = r_inst_pc;
   assign bus.retire_cnt = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_ctrl : directed bench with a transaction-level fetch model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fetch_ctrl;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   lat;
   int   wcnt;
   logic ack_force;

   fetch_ctrl_if bus();

   fetch_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // Memory responder: acks after lat wait cycles; ack_force injects a stray ack.
   always @(posedge clk) begin
      if (!bus.imem_req || bus.imem_ack) wcnt <= 0;
      else                               wcnt <= wcnt + 1;
   end
   assign bus.imem_ack   = ack_force | (bus.imem_req && (wcnt >= lat));
   assign bus.imem_rdata = memfn(bus.imem_addr);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: outstanding request, discard flag, held word.
   logic        m_busy, m_discard, m_hold;
   logic [31:0] m_pc, m_addr, m_inst, m_inst_pc, m_cnt;

   always @(negedge clk) begin
      logic [31:0] tgt;
      chk("imem_req",   {31'd0, bus.imem_req},   {31'd0, m_busy});
      chk("imem_addr",  bus.imem_addr,           m_addr);
      chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, m_hold && !bus.redirect_valid});
      chk("inst",       bus.inst,                m_inst);
      chk("inst_pc",    bus.inst_pc,             m_inst_pc);
      chk("retire_cnt", bus.retire_cnt,          m_cnt);

      // Inputs are stable from here until the next rising edge samples them.
      if (!rst_n) begin
         m_busy = 0; m_discard = 0; m_hold = 0;
         m_pc = 32'h3000; m_addr = 32'h3000;
         m_inst = 0; m_inst_pc = 0; m_cnt = 0;
      end else if (m_busy) begin
         tgt = bus.redirect_valid ? (bus.redirect_pc & ~32'h3) : m_pc;
         if (bus.imem_ack) begin
            if (m_discard || bus.redirect_valid) begin
               m_addr = tgt; m_discard = 0;
            end else begin
               m_inst = memfn(m_addr); m_inst_pc = m_addr;
               m_busy = 0; m_hold = 1;
            end
         end else if (bus.redirect_valid) begin
            m_discard = 1;
         end
         m_pc = tgt;
      end else if (m_hold) begin
         if (bus.redirect_valid) begin
            m_pc = bus.redirect_pc & ~32'h3;
            m_hold = 0; m_busy = 1; m_addr = m_pc;
         end else if (bus.inst_ready) begin
            m_pc = bus.npc & ~32'h3; m_cnt = m_cnt + 1;
            m_hold = 0; m_busy = 1; m_addr = m_pc;
         end
      end else begin
         m_busy = 1; m_discard = 0; m_addr = m_pc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0; bad = 0;
      m_busy = 0; m_discard = 0; m_hold = 0;
      m_pc = 32'h3000; m_addr = 32'h3000; m_inst = 0; m_inst_pc = 0; m_cnt = 0;
      rst_n = 0; lat = 0; ack_force = 0;
      bus.redirect_valid = 0; bus.redirect_pc = 0; bus.inst_ready = 0; bus.npc = 0;

      tick();
      @(negedge clk);
      chk("rst req", {31'd0, bus.imem_req}, 32'd0);
      chk("rst addr", bus.imem_addr, 32'h3000);
      chk("rst cnt", bus.retire_cnt, 32'd0);
      tick();
      rst_n = 1;
      @(negedge clk); chk("idle req", {31'd0, bus.imem_req}, 32'd0);
      tick();
      @(negedge clk);
      chk("first req", {31'd0, bus.imem_req}, 32'd1);
      chk("first addr", bus.imem_addr, 32'h3000);
      tick();
      bus.inst_ready = 1; bus.npc = 32'h3004;
      @(negedge clk);
      chk("first valid", {31'd0, bus.inst_valid}, 32'd1);
      chk("first inst_pc", bus.inst_pc, 32'h3000);
      tick();
      bus.inst_ready = 0;
      @(negedge clk);
      chk("seq addr", bus.imem_addr, 32'h3004);
      chk("seq cnt", bus.retire_cnt, 32'd1);
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall req", {31'd0, bus.imem_req}, 32'd0);
         chk("stall inst_pc", bus.inst_pc, 32'h3004);
         chk("stall cnt", bus.retire_cnt, 32'd1);
         tick();
      end
      bus.inst_ready = 1; bus.npc = 32'h3100;
      @(negedge clk); tick();
      bus.inst_ready = 0;
      @(negedge clk); chk("branch addr", bus.imem_addr, 32'h3100);
      tick();
      bus.inst_ready = 1; bus.npc = 32'h3008; lat = 2;
      @(negedge clk); tick();
      bus.inst_ready = 0; bus.redirect_valid = 1; bus.redirect_pc = 32'h4000;
      @(negedge clk); chk("slow addr", bus.imem_addr, 32'h3008);
      tick();
      bus.redirect_pc = 32'h4180;
      @(negedge clk); chk("drain addr", bus.imem_addr, 32'h3008);
      tick();
      bus.redirect_valid = 0;
      @(negedge clk); chk("drain hold", bus.imem_addr, 32'h3008);
      tick();
      @(negedge clk); chk("redir addr", bus.imem_addr, 32'h4180);
      tick();
      @(negedge clk); chk("redir nodata", {31'd0, bus.inst_valid}, 32'd0);
      tick();
      @(negedge clk); tick();
      lat = 0; bus.inst_ready = 1; bus.npc = 32'h4184;
      bus.redirect_valid = 1; bus.redirect_pc = 32'h5003;
      @(negedge clk);
      chk("mask valid", {31'd0, bus.inst_valid}, 32'd0);
      chk("held inst_pc", bus.inst_pc, 32'h4180);
      chk("held inst", bus.inst, memfn(32'h4180));
      tick();
      bus.inst_ready = 0; bus.redirect_pc = 32'h6000;
      @(negedge clk);
      chk("mask addr", bus.imem_addr, 32'h5000);
      chk("mask cnt", bus.retire_cnt, 32'd3);
      tick();
      bus.redirect_valid = 0;
      @(negedge clk); chk("ack+redir addr", bus.imem_addr, 32'h6000);
      tick();
      bus.inst_ready = 1; bus.npc = 32'h7000; lat = 5;
      @(negedge clk); tick();
      bus.inst_ready = 0; bus.redirect_valid = 1; bus.redirect_pc = 32'h8000;
      @(negedge clk); chk("pre cnt", bus.retire_cnt, 32'd4);
      tick();
      bus.redirect_valid = 0; rst_n = 0; ack_force = 1;
      @(negedge clk); tick();
      @(negedge clk);
      chk("rst2 req", {31'd0, bus.imem_req}, 32'd0);
      chk("rst2 inst_pc", bus.inst_pc, 32'd0);
      tick();
      rst_n = 1;
      @(negedge clk); tick();
      ack_force = 0; lat = 0;
      @(negedge clk);
      chk("rst2 first addr", bus.imem_addr, 32'h3000);
      chk("rst2 first req", {31'd0, bus.imem_req}, 32'd1);
      tick();
      @(negedge clk); chk("rst2 inst", bus.inst, memfn(32'h3000));
      tick();
      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequences instruction fetch around the next-PC unit: owns the PC register, issues single-outstanding requests to instruction memory, and hands each fetched word to decode with a valid/ready handshake. On consumption it loads the PC from the next-PC unit's `npc`. An asynchronous-to-pipeline redirect (exception/eret) squashes the held instruction or drains an in-flight fetch. Sits between instruction memory, decode and `npc`.

## Interface
- `RESET_PC`, 32'h0000_3000, first fetch address after reset.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `npc`  in  32  next PC from the next-PC unit; sampled only in a consume cycle.
- `redirect_valid`  in  1  force fetch to `redirect_pc`; single-cycle pulse or level.
- `redirect_pc`  in  32  redirect target.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; stable while `imem_req` is high.
- `imem_ack`  in  1  request complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `inst_valid`  out  1  `inst`/`inst_pc` valid to decode.
- `inst`  out  32  held instruction.
- `inst_pc`  out  32  address of `inst`.
- `inst_ready`  in  1  decode accepts (low = stall).
- `retire_cnt`  out  32  count of consumed instructions, wraps modulo 2^32.

## Operation
- States: IDLE, FETCH, HOLD, DRAIN.
- Registers: `pc` (next address to fetch), `imem_addr`, `inst`, `inst_pc`, `retire_cnt`, state. `pc[1:0]` is always 00; bits [1:0] of `npc`/`redirect_pc` are dropped.
- IDLE: entered only from reset; unconditionally goes to FETCH next cycle. `imem_addr <= pc`.
- FETCH: `imem_req`=1, `imem_addr` = address launched on entry.
  - `redirect_valid` & `imem_ack`: data discarded, `pc <= redirect_pc`, stay in FETCH, new request next cycle at `redirect_pc`.
  - `redirect_valid` & !`imem_ack`: `pc <= redirect_pc`, go to DRAIN.
  - `imem_ack` only: `inst <= imem_rdata`, `inst_pc <= imem_addr`, go to HOLD.
- DRAIN: `imem_req`=1 with the old `imem_addr`. A further redirect overwrites `pc` (latest wins). On `imem_ack`, data is discarded and state goes to FETCH with `imem_addr <= pc`.
- HOLD: `inst_valid` = !`redirect_valid` (combinational mask).
  - redirect: `pc <= redirect_pc`, go to FETCH; not counted as consumed.
  - else `inst_ready`: consume; `pc <= npc`, `retire_cnt++`, go to FETCH.
- Every entry into FETCH loads `imem_addr` from the updated PC value. A direct redirect target is used the same cycle.
- `imem_ack` in IDLE or HOLD is ignored.

## Timing
- Reset values: state IDLE, `pc`=`imem_addr`=RESET_PC, `inst`=`inst_pc`=0, `retire_cnt`=0, `imem_req`=0, `inst_valid`=0.
- Reset mid-operation returns to IDLE the next cycle. Any outstanding request is abandoned, and a late ack is ignored.
- First `imem_req` occurs the cycle after `rst_n` rises.
- Zero-wait memory (ack in the request's first cycle) gives `inst_valid` the next cycle. Peak throughput is 1 instruction per 2 cycles.
- Consume-to-next-request latency is 1 cycle, with `imem_addr` = `npc` of the consume cycle.
- `imem_req`/`inst_valid` are derived from state (plus the HOLD redirect mask); all other outputs are registered.

## Structure
- Package `fetch_pkg`: state enum (IDLE, FETCH, HOLD, DRAIN) and the default `RESET_PC` constant.
- Single module; no sub-module warranted.

## Test plan
- Reset release with ack tied high: `imem_req` is high the cycle after reset with `imem_addr`=0x3000. `inst_valid` follows with `inst_pc`=0x3000. `inst_ready`=1 with `npc`=0x3004 gives the next request at 0x3004 and `retire_cnt`=1.
- Stall: hold `inst_ready`=0 for 5 cycles in HOLD. `inst`/`inst_pc` stay stable, `imem_req`=0, and `retire_cnt` is unchanged.
- Branch: consume with `npc`=0x3100. The next `imem_addr` is 0x3100.
- Redirect during a 3-cycle-latency fetch at 0x3008 to 0x0000_4180:
  - `imem_addr` holds 0x3008 until ack, and that data never reaches `inst_valid`.
  - The next request is to 0x4180.
- Redirect and `inst_ready` in the same HOLD cycle: `inst_valid`=0 that cycle, `retire_cnt` is unchanged, and the next fetch is at `redirect_pc`.
- Reset asserted while in DRAIN, then ack arrives: the ack is ignored, and the first post-reset fetch is at 0x3000.
